// File: rtl/lifelike_cell.sv
// Registered Life-like (Bx/Sy) cell with programmable rule masks, saturating age and stable flag.
// Optional period-2 oscillation detector is enabled by defining LIFELIKE_CELL_OSC2_EN.
module lifelike_cell #(
    parameter int N_NEIGH = 8,
    parameter int AGE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               state_0,
    input  logic               rule_load,
    input  logic [N_NEIGH:0]   birth_mask,
    input  logic [N_NEIGH:0]   survive_mask,
    input  logic [N_NEIGH-1:0] neighbors,
    output logic               state_q,
    output logic               state_d,
    output logic [AGE_W-1:0]   age,
    output logic               stable,
    output logic               osc2
);

    localparam int CNT_W = $clog2(N_NEIGH + 1);

    // B3/S23; bits above N_NEIGH fall away when the masks are narrower.
    localparam logic [8:0] BIRTH_RST   = 9'b0_0000_1000;
    localparam logic [8:0] SURVIVE_RST = 9'b0_0000_1100;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_NEIGH-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_NEIGH; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + AGE_W'(1);
    endfunction

    logic               r_state;
    logic [AGE_W-1:0]   r_age;
    logic               r_stable;
    logic [N_NEIGH:0]   r_birth;
    logic [N_NEIGH:0]   r_survive;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_next;

    assign w_cnt  = popcount(neighbors);
    assign w_next = r_state ? r_survive[w_cnt] : r_birth[w_cnt];

    // Generation register stage: state, age, stable and rule masks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= state_0;
            r_age     <= '0;
            r_stable  <= 1'b0;
            r_birth   <= BIRTH_RST[N_NEIGH:0];
            r_survive <= SURVIVE_RST[N_NEIGH:0];
        end else begin
            if (rule_load) begin
                r_birth   <= birth_mask;
                r_survive <= survive_mask;
            end
            if (ena) begin
                r_state  <= w_next;
                r_stable <= (w_next == r_state);
                if (!w_next) begin
                    r_age <= '0;
                end else if (!r_state) begin
                    r_age <= AGE_W'(1);
                end else begin
                    r_age <= age_sat_inc(r_age);
                end
            end
        end
    end

`ifdef LIFELIKE_CELL_OSC2_EN
    logic r_prev1;
    logic r_prev2;
    logic r_hist_vld_p1;
    logic r_hist_vld_p2;
    logic r_osc2;

    // History stage: previous two states travel with their own valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev1       <= 1'b0;
            r_prev2       <= 1'b0;
            r_hist_vld_p1 <= 1'b0;
            r_hist_vld_p2 <= 1'b0;
            r_osc2        <= 1'b0;
        end else if (ena) begin
            r_prev2       <= r_prev1;
            r_prev1       <= r_state;
            r_hist_vld_p1 <= 1'b1;
            r_hist_vld_p2 <= r_hist_vld_p1;
            r_osc2        <= r_hist_vld_p2 && (w_next == r_prev1) && (w_next != r_state);
        end
    end

    assign osc2 = r_osc2;
`else
    assign osc2 = 1'b0;
`endif

    assign state_q = r_state;
    assign state_d = w_next;
    assign age     = r_age;
    assign stable  = r_stable;

endmodule

// File: tb/tb_lifelike_cell.sv
// Directed, table-driven bench for lifelike_cell (Moore N=8 instance plus a von Neumann N=4 instance).
module tb_lifelike_cell;

`ifdef LIFELIKE_CELL_OSC2_EN
    localparam bit OSC_ON = 1'b1;
`else
    localparam bit OSC_ON = 1'b0;
`endif

    logic       clk;
    logic       rst, ena, state_0, rule_load;
    logic [8:0] birth_mask, survive_mask;
    logic [7:0] neighbors;
    logic       state_q, state_d, stable, osc2;
    logic [3:0] age;

    logic       rst4, ena4, s04, rl4;
    logic [4:0] bm4, sm4;
    logic [3:0] nb4;
    logic       q4, d4, st4, osc4;
    logic [3:0] age4;

    lifelike_cell #(.N_NEIGH(8), .AGE_W(4)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .rule_load(rule_load),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .neighbors(neighbors),
        .state_q(state_q), .state_d(state_d), .age(age), .stable(stable), .osc2(osc2)
    );

    lifelike_cell #(.N_NEIGH(4), .AGE_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .ena(ena4), .state_0(s04), .rule_load(rl4),
        .birth_mask(bm4), .survive_mask(sm4), .neighbors(nb4),
        .state_q(q4), .state_d(d4), .age(age4), .stable(st4), .osc2(osc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       s0;
        logic       ena;
        logic       rl;
        logic [8:0] bm;
        logic [8:0] sm;
        logic [7:0] nb;
        logic       chk_d;
        logic       exp_d;
        logic       exp_q;
        logic [3:0] exp_age;
        logic       exp_st;
        logic       exp_osc;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl[NV];
    int   n_tbl;
    int   n_vec;
    int   n_bad;

    task automatic add(input logic r, input logic s0, input logic en, input logic rl,
                       input logic [8:0] bm, input logic [8:0] sm, input logic [7:0] nb,
                       input logic cd, input logic d, input logic q, input logic [3:0] a,
                       input logic st, input logic osc);
        tbl[n_tbl] = '{rst: r, s0: s0, ena: en, rl: rl, bm: bm, sm: sm, nb: nb, chk_d: cd,
                       exp_d: d, exp_q: q, exp_age: a, exp_st: st, exp_osc: osc};
        n_tbl++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    localparam logic [8:0] B3  = 9'h008;
    localparam logic [8:0] S23 = 9'h00C;
    localparam logic [8:0] B6  = 9'h040;

    initial begin
        n_tbl = 0; n_vec = 0; n_bad = 0;
        rst = 1'b1; ena = 1'b0; state_0 = 1'b0; rule_load = 1'b0;
        birth_mask = '0; survive_mask = '0; neighbors = '0;
        rst4 = 1'b1; ena4 = 1'b0; s04 = 1'b0; rl4 = 1'b0; bm4 = '0; sm4 = '0; nb4 = '0;

        //   rst s0 en rl  bm      sm     nb     cd d  q  age st osc(with OSC2)
        add(1, 1, 1, 0, 9'h0,   9'h0,  8'h07, 0, 0, 1, 0,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h07, 1, 1, 1, 1,  1, 0);
        add(1, 0, 0, 0, 9'h0,   9'h0,  8'h00, 0, 0, 0, 0,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h15, 1, 1, 1, 1,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h0F, 1, 0, 0, 0,  0, 0);
        add(0, 0, 0, 0, 9'h0,   9'h0,  8'h07, 1, 1, 0, 0,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h00, 1, 0, 0, 0,  1, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'hFF, 1, 0, 0, 0,  1, 0);
        add(0, 0, 1, 1, B6,     S23,   8'h07, 1, 1, 1, 1,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h00, 1, 0, 0, 0,  0, 1);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h07, 1, 0, 0, 0,  1, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h3F, 1, 1, 1, 1,  0, 0);
        add(1, 1, 1, 1, 9'h1FF, 9'h0,  8'h00, 0, 0, 1, 0,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h03, 1, 1, 1, 1,  1, 0);
        // blinker: 1,0,1,0,1 then hold, then reset clears history
        add(1, 1, 0, 0, 9'h0,   9'h0,  8'h00, 0, 0, 1, 0,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h00, 1, 0, 0, 0,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h07, 1, 1, 1, 1,  0, 0);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h00, 1, 0, 0, 0,  0, 1);
        add(0, 0, 1, 0, 9'h0,   9'h0,  8'h07, 1, 1, 1, 1,  0, 1);
        add(0, 0, 0, 0, 9'h0,   9'h0,  8'h00, 1, 0, 1, 1,  0, 1);
        add(1, 0, 0, 0, 9'h0,   9'h0,  8'h00, 0, 0, 0, 0,  0, 0);

        for (int i = 0; i < n_tbl; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; state_0 = tbl[i].s0; ena = tbl[i].ena; rule_load = tbl[i].rl;
            birth_mask = tbl[i].bm; survive_mask = tbl[i].sm; neighbors = tbl[i].nb;
            #1;
            if (tbl[i].chk_d) chk("state_d", i, 32'(state_d), 32'(tbl[i].exp_d));
            @(posedge clk);
            #1;
            n_vec++;
            chk("state_q", i, 32'(state_q), 32'(tbl[i].exp_q));
            chk("age",     i, 32'(age),     32'(tbl[i].exp_age));
            chk("stable",  i, 32'(stable),  32'(tbl[i].exp_st));
            chk("osc2",    i, 32'(osc2),    32'(tbl[i].exp_osc & OSC_ON));
        end

        // age saturation: live cell with 2 neighbours, ena held 20 cycles
        @(negedge clk);
        rst = 1'b1; state_0 = 1'b1; ena = 1'b0; rule_load = 1'b0; neighbors = 8'h03;
        @(negedge clk);
        rst = 1'b0; ena = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            chk("age_sat",   i, 32'(age),     (i + 1 < 15) ? 32'(i + 1) : 32'd15);
            chk("age_sat_q", i, 32'(state_q), 32'd1);
            chk("age_sat_st", i, 32'(stable), 32'd1);
        end
        @(negedge clk);
        ena = 1'b0;

        // von Neumann instance: all four neighbours live
        @(negedge clk);
        rst4 = 1'b1; s04 = 1'b1; nb4 = 4'hF; ena4 = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        chk("n4_rst_q", 0, 32'(q4), 32'd1);
        chk("n4_rst_osc", 0, 32'(osc4), 32'd0);
        @(negedge clk);
        rst4 = 1'b0; ena4 = 1'b1;
        #1;
        chk("n4_live_d", 1, 32'(d4), 32'd0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("n4_live_q", 1, 32'(q4), 32'd0);
        chk("n4_age", 1, 32'(age4), 32'd0);
        @(negedge clk);
        #1;
        chk("n4_dead_d", 2, 32'(d4), 32'd0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("n4_dead_q", 2, 32'(q4), 32'd0);
        chk("n4_stable", 2, 32'(st4), 32'd1);
        @(negedge clk);
        ena4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
